uart_cmd_bridge: RTL and testbench

//  Host-side consumer of the UART transceiver's FIFO ports: pops command bytes from the RX FIFO,

---
 rtl/uart_bridge_pkg.sv | 31 +++
 rtl/uart_bridge_timer.sv | 37 +++
 rtl/uart_cmd_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared state encoding and protocol byte values for the UART
//               command bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_BUS  = 3'd5,
        S_RESP = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] CMD_RD     = 8'h52;
    localparam logic [7:0] RSP_OK     = 8'h4B;
    localparam logic [7:0] RSP_DATA   = 8'h44;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;
    localparam logic [7:0] RSP_TMO    = 8'h54;
    localparam logic [7:0] RSP_CSUM   = 8'h21;

endpackage

`default_nettype wire

// File: rtl/uart_bridge_timer.sv
// ============================================================================
// Module      : uart_bridge_timer
// Description : Loadable down-counter; flags expiry once it has counted the
//               loaded number of enabled cycles without a reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bridge_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A reload in the same cycle always wins over expiry.
    assign o_expired = i_en && !i_load && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_bridge.sv
// ============================================================================
// Module      : uart_cmd_bridge
// Description : Decodes register-access commands popped from a UART RX FIFO,
//               runs a req/ack register bus and pushes replies to the TX FIFO.
//               Optional trailing checksum byte: UART_BRIDGE_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int BUS_TIMEOUT  = 255,
    parameter int IDLE_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_rdata,
    input  logic       rx_empty,
    output logic       rx_rd,
    output logic [7:0] tx_wdata,
    output logic       tx_wr,
    input  logic       tx_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_req,
    input  logic       reg_ack,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam logic [7:0]  c_bus_load  = 8'(BUS_TIMEOUT);
    localparam logic [15:0] c_idle_load = 16'(IDLE_TIMEOUT);
`ifdef UART_BRIDGE_CHECKSUM_EN
    localparam state_t c_after_payload = S_CSUM;
`else
    localparam state_t c_after_payload = S_BUS;
`endif

    state_t     r_state;
    state_t     w_next;
    logic       r_pending;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_resp0;
    logic [7:0] r_resp1;
    logic       r_resp_two;
    logic       r_resp_idx;
    logic [7:0] r_err_cnt;
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    logic       w_rx_rd;
    logic       w_req;
    logic       w_tx_wr;
    logic       w_set_resp;
    logic [7:0] w_rsp0;
    logic [7:0] w_rsp1;
    logic       w_rsp_two;
    logic       w_err_inc;
    logic       w_in_payload;
    logic       w_bus_exp;
    logic       w_idle_exp;

    assign w_in_payload = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);

    uart_bridge_timer #(.WIDTH(8)) u_bus_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (r_state != S_BUS),
        .i_load_val (c_bus_load),
        .i_en       (r_state == S_BUS),
        .o_expired  (w_bus_exp)
    );

    // Reloaded on every captured byte so the limit is the gap between bytes.
    uart_bridge_timer #(.WIDTH(16)) u_idle_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (!w_in_payload || r_pending),
        .i_load_val (c_idle_load),
        .i_en       (w_in_payload),
        .o_expired  (w_idle_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rx_rd    = 1'b0;
        w_req      = 1'b0;
        w_tx_wr    = 1'b0;
        w_set_resp = 1'b0;
        w_rsp0     = RSP_OK;
        w_rsp1     = 8'h00;
        w_rsp_two  = 1'b0;
        w_err_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rx_empty && !r_pending) begin
                    w_rx_rd = 1'b1;
                    w_next  = S_CMD;
                end
            end
            S_CMD: begin
                if ((rx_rdata == CMD_WR) || (rx_rdata == CMD_RD)) begin
                    w_next = S_ADDR;
                end else begin
                    w_set_resp = 1'b1;
                    w_rsp0     = RSP_BADCMD;
                    w_err_inc  = 1'b1;
                    w_next     = S_RESP;
                end
            end
            S_ADDR: begin
                if (r_pending) begin
                    w_next = r_we ? S_DATA : c_after_payload;
                end else if (w_idle_exp) begin
                    w_next = S_IDLE;
                end else begin
                    w_rx_rd = !rx_empty;
                end
            end
            S_DATA: begin
                if (r_pending) begin
                    w_next = c_after_payload;
                end else if (w_idle_exp) begin
                    w_next = S_IDLE;
                end else begin
                    w_rx_rd = !rx_empty;
                end
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            S_CSUM: begin
                if (r_pending) begin
                    if (rx_rdata == r_csum) begin
                        w_next = S_BUS;
                    end else begin
                        w_set_resp = 1'b1;
                        w_rsp0     = RSP_CSUM;
                        w_err_inc  = 1'b1;
                        w_next     = S_RESP;
                    end
                end else if (w_idle_exp) begin
                    w_next = S_IDLE;
                end else begin
                    w_rx_rd = !rx_empty;
                end
            end
`endif
            S_BUS: begin
                w_req = !w_bus_exp;
                if (w_bus_exp) begin
                    w_set_resp = 1'b1;
                    w_rsp0     = RSP_TMO;
                    w_err_inc  = 1'b1;
                    w_next     = S_RESP;
                end else if (reg_ack) begin
                    w_set_resp = 1'b1;
                    w_rsp0     = r_we ? RSP_OK : RSP_DATA;
                    w_rsp1     = reg_rdata;
                    w_rsp_two  = !r_we;
                    w_next     = S_RESP;
                end
            end
            S_RESP: begin
                w_tx_wr = !tx_full;
                if (!tx_full && (r_resp_idx || !r_resp_two)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_resp0    <= 8'h00;
            r_resp1    <= 8'h00;
            r_resp_two <= 1'b0;
            r_resp_idx <= 1'b0;
            r_err_cnt  <= 8'h00;
`ifdef UART_BRIDGE_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            // rx_rdata is valid exactly one cycle after the read strobe.
            r_pending <= w_rx_rd;
            if (r_state == S_CMD) begin
                r_we <= (rx_rdata == CMD_WR);
`ifdef UART_BRIDGE_CHECKSUM_EN
                r_csum <= rx_rdata;
`endif
            end
            if ((r_state == S_ADDR) && r_pending) begin
                r_addr <= rx_rdata;
`ifdef UART_BRIDGE_CHECKSUM_EN
                r_csum <= r_csum ^ rx_rdata;
`endif
            end
            if ((r_state == S_DATA) && r_pending) begin
                r_wdata <= rx_rdata;
`ifdef UART_BRIDGE_CHECKSUM_EN
                r_csum <= r_csum ^ rx_rdata;
`endif
            end
            if (w_set_resp) begin
                r_resp0    <= w_rsp0;
                r_resp1    <= w_rsp1;
                r_resp_two <= w_rsp_two;
                r_resp_idx <= 1'b0;
            end else if ((r_state == S_RESP) && w_tx_wr) begin
                r_resp_idx <= 1'b1;
            end
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign rx_rd     = w_rx_rd;
    assign tx_wr     = w_tx_wr;
    assign tx_wdata  = r_resp_idx ? r_resp1 : r_resp0;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_req   = w_req;
    assign busy      = (r_state != S_IDLE);
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
// ============================================================================
// Module      : tb_uart_cmd_bridge
// Description : Directed self-checking bench for uart_cmd_bridge with FIFO and
//               register-bus models. Honours UART_BRIDGE_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_bridge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_rdata = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_rd;
    logic [7:0] tx_wdata;
    logic       tx_wr;
    logic       tx_full = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_req;
    logic       reg_ack = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tb_csum = 8'h00;

    int         ack_delay    = 3;
    logic [7:0] rd_value     = 8'h00;
    logic       spurious_ack = 1'b0;
    int         req_cycles   = 0;
    int         last_req_len = 0;
    int         req_events   = 0;
    logic       prev_req     = 1'b0;
    logic       prev_rd      = 1'b0;
    logic [7:0] cap_addr     = 8'h00;
    logic [7:0] cap_wdata    = 8'h00;
    logic       cap_we       = 1'b0;
    int         rd_viol      = 0;
    int         tx_viol      = 0;
    int         stable_viol  = 0;

    uart_cmd_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .rx_rdata  (rx_rdata),
        .rx_empty  (rx_empty),
        .rx_rd     (rx_rd),
        .tx_wdata  (tx_wdata),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_req   (reg_req),
        .reg_ack   (reg_ack),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // FIFO models: standard (non-FWFT) RX read, TX capture on write strobe.
    always @(posedge clk) begin
        if (rx_rd) begin
            if (rx_empty || prev_rd || (rx_q.size() == 0)) rd_viol++;
            if (rx_q.size() > 0) rx_rdata <= rx_q.pop_front();
        end
        prev_rd <= rx_rd;
        if (tx_wr) begin
            if (tx_full) tx_viol++;
            tx_q.push_back(tx_wdata);
        end
    end

    always @(negedge clk) rx_empty <= (rx_q.size() == 0);

    // Register-bus responder: acks on the ack_delay-th request cycle (0 = never).
    always @(negedge clk) begin
        if (reg_req) begin
            req_cycles++;
            if (!prev_req) begin
                req_events++;
                cap_addr  = reg_addr;
                cap_wdata = reg_wdata;
                cap_we    = reg_we;
            end else if ((reg_addr !== cap_addr) || (reg_wdata !== cap_wdata) || (reg_we !== cap_we)) begin
                stable_viol++;
            end
        end else if (prev_req) begin
            last_req_len = req_cycles;
            req_cycles   = 0;
        end
        prev_req  = reg_req;
        reg_ack   = spurious_ack || (reg_req && (ack_delay != 0) && (req_cycles == ack_delay));
        reg_rdata = rd_value;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        tb_csum ^= b;
    endtask

    task automatic end_cmd();
`ifdef UART_BRIDGE_CHECKSUM_EN
        rx_q.push_back(tb_csum);
`endif
        tb_csum = 8'h00;
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int k = 0;
        while ((tx_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_txcnt"}, tx_q.size(), n);
    endtask

    function automatic logic [7:0] tx_at(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction

    initial begin
        tick(3);
        check_eq("rst_rx_rd", rx_rd, 1'b0);
        check_eq("rst_tx_wr", tx_wr, 1'b0);
        check_eq("rst_tx_wdata", tx_wdata, 8'h00);
        check_eq("rst_reg_req", reg_req, 1'b0);
        check_eq("rst_reg_we", reg_we, 1'b0);
        check_eq("rst_reg_addr", reg_addr, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err_cnt", err_cnt, 8'h00);
        reset = 1'b0;
        tick(2);

        // Reset in the middle of a command drops it without a reply.
        push_byte(8'h57); push_byte(8'h10);
        tb_csum = 8'h00;
        tick(6);
        check_eq("midrst_busy_before", busy, 1'b1);
        reset = 1'b1;
        rx_q.delete();
        tick(2);
        reset = 1'b0;
        tick(20);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_tx", tx_q.size(), 0);
        check_eq("midrst_req", req_events, 0);

        // Write: 57,10,A5 with ack on the third request cycle.
        tx_q.delete(); req_events = 0; ack_delay = 3;
        push_byte(8'h57); push_byte(8'h10); push_byte(8'hA5); end_cmd();
        wait_tx("wr", 1, 200);
        tick(2);
        check_eq("wr_rsp", tx_at(0), 8'h4B);
        check_eq("wr_req_events", req_events, 1);
        check_eq("wr_we", cap_we, 1'b1);
        check_eq("wr_addr", cap_addr, 8'h10);
        check_eq("wr_wdata", cap_wdata, 8'hA5);
        check_eq("wr_req_len", last_req_len, 3);
        check_eq("wr_busy", busy, 1'b0);

        // Read: 52,22 returning C3.
        tx_q.delete(); req_events = 0; rd_value = 8'hC3;
        push_byte(8'h52); push_byte(8'h22); end_cmd();
        wait_tx("rd", 2, 200);
        tick(2);
        check_eq("rd_rsp0", tx_at(0), 8'h44);
        check_eq("rd_rsp1", tx_at(1), 8'hC3);
        check_eq("rd_we", cap_we, 1'b0);
        check_eq("rd_addr", cap_addr, 8'h22);
        check_eq("rd_busy", busy, 1'b0);
        check_eq("rd_err_cnt", err_cnt, 8'h00);

        // Bad command byte consumes only itself; the following read still works.
        tx_q.delete(); req_events = 0; rd_value = 8'h5A;
        push_byte(8'h99); tb_csum = 8'h00;
        push_byte(8'h52); push_byte(8'h00); end_cmd();
        wait_tx("bad", 3, 300);
        tick(2);
        check_eq("bad_rsp", tx_at(0), 8'h3F);
        check_eq("bad_rd_rsp0", tx_at(1), 8'h44);
        check_eq("bad_rd_rsp1", tx_at(2), 8'h5A);
        check_eq("bad_req_events", req_events, 1);
        check_eq("bad_rd_addr", cap_addr, 8'h00);
        check_eq("bad_err_cnt", err_cnt, 8'h01);

        // Bus timeout: no ack at all.
        tx_q.delete(); req_events = 0; ack_delay = 0;
        push_byte(8'h52); push_byte(8'h05); end_cmd();
        wait_tx("tmo", 1, 800);
        tick(2);
        check_eq("tmo_rsp", tx_at(0), 8'h54);
        check_eq("tmo_req_len", last_req_len, 255);
        check_eq("tmo_req_events", req_events, 1);
        check_eq("tmo_err_cnt", err_cnt, 8'h02);
        check_eq("tmo_busy", busy, 1'b0);
        ack_delay = 3;

        // TX backpressure during a read reply.
        tx_q.delete(); tx_full = 1'b1; rd_value = 8'h77;
        push_byte(8'h52); push_byte(8'h33); end_cmd();
        tick(40);
        check_eq("bp_held_tx", tx_q.size(), 0);
        check_eq("bp_held_busy", busy, 1'b1);
        tx_full = 1'b0;
        wait_tx("bp", 2, 100);
        check_eq("bp_rsp0", tx_at(0), 8'h44);
        check_eq("bp_rsp1", tx_at(1), 8'h77);

        // Ack with no request outstanding has no effect.
        tick(3);
        tx_q.delete(); req_events = 0; spurious_ack = 1'b1;
        tick(5);
        spurious_ack = 1'b0;
        tick(2);
        check_eq("spur_busy", busy, 1'b0);
        check_eq("spur_tx", tx_q.size(), 0);

        // Incomplete command followed by silence is discarded quietly.
        tx_q.delete(); req_events = 0;
        push_byte(8'h57); push_byte(8'h10); tb_csum = 8'h00;
        tick(20);
        check_eq("idle_busy_wait", busy, 1'b1);
        tick(65535 + 20);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_tx", tx_q.size(), 0);
        check_eq("idle_req", req_events, 0);
        check_eq("idle_err_cnt", err_cnt, 8'h02);

        // Error counter saturates at FF.
        tx_q.delete();
        for (int i = 0; i < 260; i++) push_byte(8'h00);
        tb_csum = 8'h00;
        wait_tx("sat", 260, 3000);
        tick(2);
        check_eq("sat_err_cnt", err_cnt, 8'hFF);
        check_eq("sat_last_rsp", tx_at(259), 8'h3F);

`ifdef UART_BRIDGE_CHECKSUM_EN
        tx_q.delete(); req_events = 0;
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5); rx_q.push_back(8'hE2);
        wait_tx("csum_ok", 1, 200);
        tick(2);
        check_eq("csum_ok_rsp", tx_at(0), 8'h4B);
        check_eq("csum_ok_req", req_events, 1);
        tx_q.delete(); req_events = 0;
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hA5); rx_q.push_back(8'h00);
        wait_tx("csum_bad", 1, 200);
        tick(2);
        check_eq("csum_bad_rsp", tx_at(0), 8'h21);
        check_eq("csum_bad_req", req_events, 0);
`endif

        check_eq("rx_rd_protocol", rd_viol, 0);
        check_eq("tx_wr_when_full", tx_viol, 0);
        check_eq("req_fields_stable", stable_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
